// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and response type for the instruction-memory fetch port.
package imem_pkg;
  localparam int IMEM_DATA_W = 32;
  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;
  typedef struct packed {
    logic err;
    logic [IMEM_DATA_W-1:0] instr;
  } imem_resp_t;
endpackage

// File: rtl/imem_resp_fifo.sv
// imem_resp_fifo: depth-D response queue with flush; a push in the flush cycle survives the flush.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter type T = imem_resp_t,
  parameter int  D = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output logic empty,
  output T     rdata
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  T mem [D];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty = cnt == '0;
  assign do_pop = pop && !empty && !flush;
  assign do_push = push && (flush || cnt != CW'(D) || do_pop);
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      rp <= '0;
      wp <= do_push ? PW'(1) : '0;
      cnt <= CW'(do_push);
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop) rp <= inc(rp);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[flush ? '0 : wp] <= wdata;
endmodule

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: instruction memory behind a valid/ready fetch port with flush, program-load and error reporting.
// Define IMEM_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 64,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_instr,
  output logic                     resp_err,
  input  logic                     flush,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data
`ifdef IMEM_PERF_EN
  ,
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);
  localparam int Q  = READ_LAT + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(Q + 1);
  typedef struct packed {
    logic err;
    logic [DATA_W-1:0] instr;
  } resp_t;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0] out_cnt;
  logic req_fire, resp_fire, addr_err, push, fifo_empty;
  resp_t rd, push_d, head;
  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("imem_fetch_port: READ_LAT must be 1 or 2");
  end
  assign req_ready = (out_cnt < CW'(Q)) || flush;
  assign req_fire = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;
  assign addr_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != '0);
  // Array is read in the accept cycle; the non-blocking write makes collisions read-first.
  assign rd = '{err: addr_err, instr: addr_err ? DATA_W'(IMEM_NOP) : mem[req_addr[AW+1:2]]};
  always_ff @(posedge clk)
    if (prog_we && rst_n) mem[prog_addr] <= prog_data;
  if (READ_LAT == 2) begin : g_lat2
    logic  s_v;
    resp_t s_d;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s_v <= 1'b0;
      else s_v <= req_fire;
    always_ff @(posedge clk)
      if (req_fire) s_d <= rd;
    assign push = s_v && !flush;
    assign push_d = s_d;
  end else begin : g_lat1
    assign push = req_fire;
    assign push_d = rd;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_cnt <= '0;
    else if (flush) out_cnt <= CW'(req_fire);
    else out_cnt <= out_cnt + CW'(req_fire) - CW'(resp_fire);
  imem_resp_fifo #(.T(resp_t), .D(Q)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (push_d),
    .pop   (resp_ready),
    .empty (fifo_empty),
    .rdata (head)
  );
  assign resp_valid = !fifo_empty;
  assign resp_instr = head.instr;
  assign resp_err = head.err;
`ifdef IMEM_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(resp_fire);
      perf_stall_cnt <= perf_stall_cnt + 32'(resp_valid && !resp_ready);
    end
`endif
endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: scoreboard bench driving a READ_LAT=1 and a READ_LAT=2 instance with shared stimulus.
module tb_imem_fetch_port;
  logic clk = 0, rst_n = 0;
  logic rv1 = 0, rv2 = 0, rr = 0, flush = 0, pwe = 0;
  logic [31:0] addr = 0, pdata = 0;
  logic [5:0] paddr = 0;
  logic rdy1, rdy2, v1, v2, err1, err2;
  logic [31:0] ins1, ins2;
`ifdef IMEM_PERF_EN
  logic [31:0] pf1, ps1, pf2, ps2;
`endif
  logic [31:0] model [64];
  logic [32:0] q1[$], q2[$];
  int fc2[$];
  int n_chk = 0, n_pass = 0, n_fire1 = 0, n_stall1 = 0, n_wait = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  imem_fetch_port #(.READ_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rdy1), .req_addr(addr),
    .resp_valid(v1), .resp_ready(rr), .resp_instr(ins1), .resp_err(err1), .flush(flush),
    .prog_we(pwe), .prog_addr(paddr), .prog_data(pdata)
`ifdef IMEM_PERF_EN
    , .perf_fetch_cnt(pf1), .perf_stall_cnt(ps1)
`endif
  );
  imem_fetch_port #(.READ_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_ready(rdy2), .req_addr(addr),
    .resp_valid(v2), .resp_ready(rr), .resp_instr(ins2), .resp_err(err2), .flush(flush),
    .prog_we(pwe), .prog_addr(paddr), .prog_data(pdata)
`ifdef IMEM_PERF_EN
    , .perf_fetch_cnt(pf2), .perf_stall_cnt(ps2)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  function automatic logic [31:0] w(input int i);
    return 32'h2000_0000 + 32'((2 * i) << 16) + 32'(4 * i + 1);
  endfunction

  function automatic logic [32:0] exp_of(input logic [31:0] a);
    logic e;
    e = (a[1:0] != 2'b00) || (a >= 32'd256);
    return {e, e ? 32'h0 : model[a[7:2]]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && v1 && !rr) n_stall1++;
    if (rst_n && !flush && v1 && rr) begin
      n_fire1++;
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL mon1: got unexpected response instr=0x%0h err=%0b, expected none", ins1, err1);
      end else chk("mon1", {31'b0, err1, ins1}, {31'b0, q1.pop_front()});
    end
    if (rst_n && !flush && v2 && rr) begin
      fc2.push_back(cyc);
      if (q2.size() == 0) begin
        n_chk++;
        $display("FAIL mon2: got unexpected response instr=0x%0h err=%0b, expected none", ins2, err2);
      end else chk("mon2", {31'b0, err2, ins2}, {31'b0, q2.pop_front()});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic prog(input int i, input logic [31:0] d);
    pwe = 1; paddr = 6'(i); pdata = d;
    @(posedge clk); #1;
    pwe = 0; model[i] = d;
  endtask

  task automatic issue(input int d, input logic [31:0] a);
    addr = a;
    if (d == 1) rv1 = 1; else rv2 = 1;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if ((d == 1) ? rdy1 : rdy2) break;
      n_wait++;
      if (k == 30) begin
        n_chk++;
        $display("FAIL issue_timeout: req_ready stayed 0 for addr 0x%0h, expected acceptance", a);
        rv1 = 0; rv2 = 0;
        return;
      end
    end
    if (d == 1) q1.push_back(exp_of(a)); else q2.push_back(exp_of(a));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rv1 = 0; rv2 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    @(negedge clk);
    chk("rst_valid1", v1, 0); chk("rst_instr1", ins1, 0); chk("rst_err1", err1, 0);
    chk("rst_ready1", rdy1, 1); chk("rst_valid2", v2, 0); chk("rst_ready2", rdy2, 1);
`ifdef IMEM_PERF_EN
    chk("rst_perf_fetch", pf1, 0); chk("rst_perf_stall", ps1, 0);
`endif
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 64; i++) prog(i, w(i));
    // basic fetch, READ_LAT=1
    rr = 1;
    issue(1, 4); idle();
    @(negedge clk);
    chk("basic_valid", v1, 1); chk("basic_instr", ins1, 32'h2002_0005); chk("basic_err", err1, 0);
    cycles(2);
    // READ_LAT=2 latency
    issue(2, 8); idle();
    @(negedge clk); chk("lat2_early", v2, 0);
    @(negedge clk); chk("lat2_valid", v2, 1);
    cycles(2);
    // streaming, READ_LAT=2
    n_wait = 0; fc2.delete();
    for (int i = 0; i < 8; i++) issue(2, 32'(4 * i));
    idle();
    chk("stream_ready_stalls", n_wait, 0);
    cycles(5);
    chk("stream_count", fc2.size(), 8);
    if (fc2.size() == 8) chk("stream_consecutive", fc2[7] - fc2[0], 7);
    // backpressure, READ_LAT=1
    rr = 0;
    issue(1, 8); issue(1, 12);
    addr = 16; rv1 = 1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", rdy1, 0); chk("bp_hold", ins1, w(2));
    end
    @(posedge clk); #1 rr = 1;
    issue(1, 16); idle();
    cycles(3);
    // address errors
    issue(1, 2); idle();
    @(negedge clk); chk("err_misaligned", err1, 1); chk("err_nop", ins1, 0);
    @(posedge clk); #1;
    issue(1, 256); issue(1, 252); issue(1, 32'hFFFF_FFFC); idle();
    cycles(3);
    // flush, READ_LAT=1
    rr = 0;
    issue(1, 0); issue(1, 4); idle();
    flush = 1; rv1 = 1; addr = 8;
    q1.delete(); q2.delete(); q1.push_back(exp_of(8));
    @(negedge clk); chk("flush_ready", rdy1, 1);
    @(posedge clk); #1 flush = 0; rv1 = 0;
    @(negedge clk); chk("flush_l1_valid", v1, 1); chk("flush_l1_instr", ins1, w(2));
    @(posedge clk); #1 rr = 1;
    cycles(3);
    // flush, READ_LAT=2
    rr = 0;
    issue(2, 0); issue(2, 4); idle();
    flush = 1; rv2 = 1; addr = 8;
    q1.delete(); q2.delete(); q2.push_back(exp_of(8));
    @(posedge clk); #1 flush = 0; rv2 = 0;
    @(negedge clk); chk("flush_l2_gap", v2, 0);
    @(negedge clk); chk("flush_l2_valid", v2, 1); chk("flush_l2_instr", ins2, w(2));
    @(posedge clk); #1 rr = 1;
    cycles(3);
    // write/read collision on word 3
    pwe = 1; paddr = 3; pdata = 32'hDEAD_BEEF;
    issue(1, 12); idle();
    pwe = 0; model[3] = 32'hDEAD_BEEF;
    @(negedge clk); chk("collide_old", ins1, w(3));
    @(posedge clk); #1;
    issue(1, 12); idle();
    @(negedge clk); chk("collide_new", ins1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    // reset mid-stream
    rr = 0;
    issue(1, 16); issue(1, 20); idle();
    @(posedge clk); #1;
`ifdef IMEM_PERF_EN
    chk("perf_fetch", pf1, 64'(n_fire1)); chk("perf_stall", ps1, 64'(n_stall1));
`endif
    rst_n = 0; pwe = 1; paddr = 5; pdata = 32'hBAD0_BAD0;
    #1;
    chk("rst_mid_valid", v1, 0); chk("rst_mid_instr", ins1, 0); chk("rst_mid_ready", rdy1, 1);
`ifdef IMEM_PERF_EN
    chk("rst_mid_perf_fetch", pf1, 0); chk("rst_mid_perf_stall", ps1, 0);
`endif
    q1.delete(); q2.delete(); n_fire1 = 0; n_stall1 = 0;
    cycles(2);
    pwe = 0; rst_n = 1;
    @(posedge clk); #1 rr = 1;
    issue(1, 20); idle();
    @(negedge clk); chk("rst_prog_ignored", ins1, w(5));
    cycles(3);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
